qed_dup_issue: RTL and testbench

Single-entry QED instruction duplicator between instruction fetch and the if_id pipeline register. Each accepted instruction is presented once as the original. When QED mode is enabled and the instruction is duplicable, it is presented a second time as a duplicate whose register fields are remapped into x16–x31. The block also drives `qed_vld_o`, which travels down the pipeline with the instruction as the QED-valid marker consumed at writeback and by the register file's commit counters.

---
 rtl/qed_dup_issue.sv | 124 ++++++++++++
 tb/tb_qed_dup_issue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_issue.sv
// Single-entry QED instruction duplicator between fetch and if_id.
// Presents each accepted instruction once, then optionally a register-remapped duplicate.
module qed_dup_issue #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        qed_vld_o,
    output logic        is_dup_o,
    output logic        illegal_o
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {EMPTY, ORIG, DUP} state_t;

    state_t      state, state_nxt;
    logic [31:0] inst_q, addr_q;
    logic        need_dup_q, illegal_q;

    logic        use_rd, use_rs1, use_rs2, dupable;
    logic        regfield_ge16, illegal_new, accept, last_beat, out_fire;
    logic [31:0] dup_inst;

    // Register fields read/written by each checked format; unchecked opcodes use none.
    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dupable = 1'b0;
        case (inst_i[6:0])
            OP_OP:              begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dupable = 1'b1; end
            OP_IMM:             begin use_rd = 1'b1; use_rs1 = 1'b1; dupable = 1'b1; end
            OP_LUI:             begin use_rd = 1'b1; dupable = 1'b1; end
            OP_LOAD, OP_JALR:   begin use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_STORE, OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JAL:             use_rd = 1'b1;
            default:            ;
        endcase
    end

    assign regfield_ge16 = (use_rd & inst_i[11]) | (use_rs1 & inst_i[19]) | (use_rs2 & inst_i[24]);
    assign illegal_new   = ena_i & regfield_ge16;

    // Nonzero fields move into x16-x31 by setting bit 4; x0 stays x0.
    always_comb begin
        dup_inst = inst_q;
        case (inst_q[6:0])
            OP_OP: begin
                dup_inst[11:7]  = {|inst_q[11:7],  inst_q[10:7]};
                dup_inst[19:15] = {|inst_q[19:15], inst_q[18:15]};
                dup_inst[24:20] = {|inst_q[24:20], inst_q[23:20]};
            end
            OP_IMM: begin
                dup_inst[11:7]  = {|inst_q[11:7],  inst_q[10:7]};
                dup_inst[19:15] = {|inst_q[19:15], inst_q[18:15]};
            end
            OP_LUI:  dup_inst[11:7] = {|inst_q[11:7], inst_q[10:7]};
            default: ;
        endcase
    end

    assign last_beat  = (state == DUP) | ((state == ORIG) & ~need_dup_q);
    assign in_ready_o = ~rst & ~flush_i & ((state == EMPTY) | (out_ready_i & last_beat));
    assign accept     = in_valid_i & in_ready_o;
    assign out_fire   = out_valid_o & out_ready_i;

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ORIG;
                ORIG:  if (out_fire) state_nxt = need_dup_q ? DUP : (accept ? ORIG : EMPTY);
                DUP:   if (out_fire) state_nxt = accept ? ORIG : EMPTY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            inst_q     <= NOP_INST;
            addr_q     <= 32'h0;
            need_dup_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                inst_q     <= inst_i;
                addr_q     <= inst_addr_i;
                illegal_q  <= illegal_new;
                need_dup_q <= ena_i & dupable & ~illegal_new;
            end
        end
    end

    assign out_valid_o = (state != EMPTY);
    assign inst_o      = (state == DUP) ? dup_inst : (illegal_q ? NOP_INST : inst_q);
    assign inst_addr_o = addr_q;
    assign qed_vld_o   = need_dup_q;
    assign is_dup_o    = (state == DUP);
    assign illegal_o   = (state == ORIG) & illegal_q;

endmodule

// File: tb/tb_qed_dup_issue.sv
// Self-checking bench for qed_dup_issue: directed scenarios plus a randomized run
// against a queue-of-beats reference model.
module tb_qed_dup_issue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, ena, flush, in_valid, in_ready, out_valid, out_ready;
    logic        qed_vld, is_dup, illegal;
    logic [31:0] inst_in, addr_in, inst_out, addr_out;

    int tests_run = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        qed;
        logic        dup;
        logic        ill;
    } beat_t;

    beat_t q[$];

    logic [31:0] b_inst[4];
    logic        b_qed[4];
    logic        b_dup[4];
    logic        b_ill[4];
    int          nb;

    always #5 clk = ~clk;

    qed_dup_issue dut (
        .clk(clk), .rst(rst), .ena_i(ena), .flush_i(flush),
        .inst_i(inst_in), .inst_addr_i(addr_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_o(inst_out), .inst_addr_o(addr_out), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .qed_vld_o(qed_vld), .is_dup_o(is_dup), .illegal_o(illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: expand one accepted instruction into the beats it must produce.
    task automatic model_accept(input logic [31:0] inst, input logic [31:0] addr, input logic en);
        int    op, rd, rs1, rs2;
        bit    u_rd, u_rs1, u_rs2, dupable, ill, nd;
        logic [31:0] d;
        beat_t b;
        op = int'(inst[6:0]); rd = int'(inst[11:7]); rs1 = int'(inst[19:15]); rs2 = int'(inst[24:20]);
        u_rd = 0; u_rs1 = 0; u_rs2 = 0; dupable = 0;
        case (op)
            'h33: begin u_rd = 1; u_rs1 = 1; u_rs2 = 1; dupable = 1; end
            'h13: begin u_rd = 1; u_rs1 = 1; dupable = 1; end
            'h37: begin u_rd = 1; dupable = 1; end
            'h03, 'h67: begin u_rd = 1; u_rs1 = 1; end
            'h23, 'h63: begin u_rs1 = 1; u_rs2 = 1; end
            'h6f: u_rd = 1;
            default: ;
        endcase
        ill = en && ((u_rd && rd >= 16) || (u_rs1 && rs1 >= 16) || (u_rs2 && rs2 >= 16));
        nd  = en && dupable && !ill;
        b.inst = ill ? NOP : inst; b.addr = addr; b.qed = nd; b.dup = 0; b.ill = ill;
        q.push_back(b);
        if (nd) begin
            d = inst;
            if (u_rd  && rd  != 0) d[11:7]  = 5'(rd + 16);
            if (u_rs1 && rs1 != 0) d[19:15] = 5'(rs1 + 16);
            if (u_rs2 && rs2 != 0) d[24:20] = 5'(rs2 + 16);
            b.inst = d; b.dup = 1; b.ill = 0;
            q.push_back(b);
        end
    endtask

    // Send one instruction into an empty DUT with out_ready high and record its beats.
    task automatic send_collect(input logic [31:0] inst, input logic en);
        nb = 0;
        in_valid = 1; inst_in = inst; addr_in = 32'h0000_0100; ena = en; flush = 0; out_ready = 1;
        step();
        in_valid = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) begin
                if (nb < 4) begin
                    b_inst[nb] = inst_out; b_qed[nb] = qed_vld; b_dup[nb] = is_dup; b_ill[nb] = illegal;
                end
                nb++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1; ena = 1; flush = 0; in_valid = 1; inst_in = 32'h003100B3; addr_in = 32'h40; out_ready = 1;
        step();
        step();
        tests_run++;
        if ({out_valid, qed_vld, is_dup, illegal, in_ready} !== 5'b0) begin
            fails++; $display("FAIL reset_flags got %b want 00000", {out_valid, qed_vld, is_dup, illegal, in_ready});
        end
        tests_run++;
        if (inst_out !== NOP || addr_out !== 32'h0) begin
            fails++; $display("FAIL reset_data got %h/%h want %h/0", inst_out, addr_out, NOP);
        end
        rst = 0; in_valid = 0;
        step();
    endtask

    task automatic test_dup_timing();
        in_valid = 1; inst_in = 32'h003100B3; addr_in = 32'h200; ena = 1; flush = 0; out_ready = 1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL s1_ready_empty got %b want 1", in_ready); end
        step();
        in_valid = 0;
        #1;
        tests_run++;
        if (inst_out !== 32'h003100B3 || qed_vld !== 1 || is_dup !== 0 || in_ready !== 0 || out_valid !== 1) begin
            fails++; $display("FAIL s1_orig got %h q%b d%b r%b v%b want 003100b3 q1 d0 r0 v1",
                              inst_out, qed_vld, is_dup, in_ready, out_valid);
        end
        step();
        tests_run++;
        if (inst_out !== 32'h013908B3 || is_dup !== 1 || qed_vld !== 1 || in_ready !== 1 || addr_out !== 32'h200) begin
            fails++; $display("FAIL s1_dup got %h d%b q%b r%b a%h want 013908b3 d1 q1 r1 a200",
                              inst_out, is_dup, qed_vld, in_ready, addr_out);
        end
        step();
        tests_run++;
        if (out_valid !== 0) begin fails++; $display("FAIL s1_drain got %b want 0", out_valid); end
    endtask

    task automatic test_remap();
        send_collect(32'h00700293, 1);
        tests_run++;
        if (nb !== 2 || b_inst[1] !== 32'h00700A93 || b_dup[1] !== 1) begin
            fails++; $display("FAIL remap_addi got n%0d %h want n2 00700a93", nb, b_inst[1]);
        end
        send_collect(32'h123450B7, 1);
        tests_run++;
        if (nb !== 2 || b_inst[1] !== 32'h123458B7 || b_inst[0] !== 32'h123450B7) begin
            fails++; $display("FAIL remap_lui got n%0d %h/%h want n2 123450b7/123458b7", nb, b_inst[0], b_inst[1]);
        end
    endtask

    task automatic test_illegal();
        send_collect(32'h001088B3, 1);
        tests_run++;
        if (nb !== 1 || b_inst[0] !== NOP || b_ill[0] !== 1 || b_qed[0] !== 0) begin
            fails++; $display("FAIL illegal_en got n%0d %h i%b q%b want n1 00000013 i1 q0", nb, b_inst[0], b_ill[0], b_qed[0]);
        end
        send_collect(32'h001088B3, 0);
        tests_run++;
        if (nb !== 1 || b_inst[0] !== 32'h001088B3 || b_ill[0] !== 0 || b_qed[0] !== 0) begin
            fails++; $display("FAIL illegal_dis got n%0d %h i%b want n1 001088b3 i0", nb, b_inst[0], b_ill[0]);
        end
    endtask

    task automatic test_back_to_back();
        ena = 1; flush = 0; out_ready = 1;
        in_valid = 1; inst_in = 32'h0020A023; addr_in = 32'h300;
        step();
        inst_in = 32'h00208463; addr_in = 32'h304;
        #1;
        tests_run++;
        if (in_ready !== 1 || inst_out !== 32'h0020A023 || qed_vld !== 0 || is_dup !== 0) begin
            fails++; $display("FAIL b2b_sw got r%b %h q%b want r1 0020a023 q0", in_ready, inst_out, qed_vld);
        end
        step();
        in_valid = 0;
        #1;
        tests_run++;
        if (out_valid !== 1 || inst_out !== 32'h00208463 || addr_out !== 32'h304 || qed_vld !== 0) begin
            fails++; $display("FAIL b2b_beq got v%b %h a%h q%b want v1 00208463 a304 q0", out_valid, inst_out, addr_out, qed_vld);
        end
        step();
        tests_run++;
        if (out_valid !== 0) begin fails++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure_flush();
        ena = 1; flush = 0; out_ready = 0;
        in_valid = 1; inst_in = 32'h003100B3; addr_in = 32'h400;
        step();
        in_valid = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (inst_out !== 32'h003100B3 || addr_out !== 32'h400 || is_dup !== 0 || in_ready !== 0 || out_valid !== 1) begin
                fails++; $display("FAIL bp_hold%0d got %h a%h d%b r%b want 003100b3 a400 d0 r0", c, inst_out, addr_out, is_dup, in_ready);
            end
            step();
        end
        out_ready = 1;
        step();
        flush = 1; in_valid = 1; inst_in = 32'h00700293; addr_in = 32'h500;
        #1;
        tests_run++;
        if (is_dup !== 1 || inst_out !== 32'h013908B3 || in_ready !== 0) begin
            fails++; $display("FAIL bp_dup got d%b %h r%b want d1 013908b3 r0", is_dup, inst_out, in_ready);
        end
        step();
        flush = 0; in_valid = 0;
        #1;
        tests_run++;
        if (out_valid !== 0) begin fails++; $display("FAIL flush_drop got v%b want 0", out_valid); end
        step();
        tests_run++;
        if (out_valid !== 0) begin fails++; $display("FAIL flush_noaccept got v%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_pair();
        ena = 1; flush = 0; out_ready = 1;
        in_valid = 1; inst_in = 32'h003100B3; addr_in = 32'h600;
        step();
        in_valid = 0;
        step();
        tests_run++;
        if (is_dup !== 1) begin fails++; $display("FAIL rst_mid_setup got d%b want 1", is_dup); end
        rst = 1;
        step();
        tests_run++;
        if (out_valid !== 0 || inst_out !== NOP || in_ready !== 0 || is_dup !== 0) begin
            fails++; $display("FAIL rst_mid got v%b %h r%b d%b want v0 00000013 r0 d0", out_valid, inst_out, in_ready, is_dup);
        end
        rst = 0;
        send_collect(32'h003100B3, 1);
        tests_run++;
        if (nb !== 2 || b_inst[0] !== 32'h003100B3 || b_inst[1] !== 32'h013908B3 || b_qed[0] !== 1 || b_dup[1] !== 1) begin
            fails++; $display("FAIL rst_mid_after got n%0d %h/%h want n2 003100b3/013908b3", nb, b_inst[0], b_inst[1]);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[10];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h17, 7'h73};
        r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 9)];
        r[11:7]  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
        r[19:15] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
        r[24:20] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic test_random();
        bit    exp_ready;
        beat_t h;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            inst_in   = rand_inst();
            addr_in   = $urandom & 32'hFFFF_FFFC;
            ena       = ($urandom_range(0, 4) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_ready = !flush && (q.size() == 0 || (out_ready && q.size() == 1));
            tests_run++;
            if (in_ready !== exp_ready || out_valid !== (q.size() != 0)) begin
                fails++; $display("FAIL rnd_hs c%0d got r%b v%b want r%b v%b", c, in_ready, out_valid, exp_ready, q.size() != 0);
            end
            if (q.size() != 0) begin
                h = q[0];
                tests_run++;
                if (inst_out !== h.inst || addr_out !== h.addr || qed_vld !== h.qed || is_dup !== h.dup || illegal !== h.ill) begin
                    fails++; $display("FAIL rnd_beat c%0d got %h a%h q%b d%b i%b want %h a%h q%b d%b i%b", c,
                                      inst_out, addr_out, qed_vld, is_dup, illegal, h.inst, h.addr, h.qed, h.dup, h.ill);
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && exp_ready) model_accept(inst_in, addr_in, ena);
            end
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_dup_timing();
        test_remap();
        test_illegal();
        test_back_to_back();
        test_backpressure_flush();
        test_reset_mid_pair();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
